// File: rtl/shot_controller.sv
// Shot controller: debounces the fire/mode/reload buttons and runs the
// IDLE/FIRE/COOLDOWN/RELOAD firing state machine that drives the ammo
// counter, fire mode and per-round shot pulse.
module shot_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES = 5000000,
    parameter int RELOAD_CYCLES   = 50000000,
    parameter int MAX_AMMO        = 31,
    parameter int BURST_LEN       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire_btn,
    input  logic       mode_btn,
    input  logic       reload_btn,
    output logic [4:0] ammo,
    output logic [2:0] shoot_mode,
    output logic       shot_pulse,
    output logic       reloading,
    output logic       empty
);

    localparam int BTN_FIRE   = 0;
    localparam int BTN_MODE   = 1;
    localparam int BTN_RELOAD = 2;

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = $clog2(BURST_LEN + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] CD_LAST    = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [TW-1:0] RL_LAST    = TW'(RELOAD_CYCLES - 1);
    localparam logic [BW-1:0] BURST_LOAD = BW'(BURST_LEN);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [4:0]    AMMO_FULL  = 5'(MAX_AMMO);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        COOLDOWN,
        RELOAD
    } state_t;

    logic [2:0]         btn_raw;
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync2_q, sync2_d;
    logic [2:0]         db_q, db_d;
    logic [2:0]         db_prev_q, db_prev_d;
    logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]         press;

    state_t             state_q, state_d;
    logic [4:0]         ammo_q, ammo_d;
    logic [1:0]         mode_q, mode_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               shot_q, shot_d;
    logic               reload_q, reload_d;
    logic               empty_q, empty_d;

    assign btn_raw = {reload_btn, mode_btn, fire_btn};
    assign press   = db_q & ~db_prev_q;

    // Synchronizer chain plus per-button debounce counter that only flips the accepted level after a full stable run.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_cnt_d  = db_cnt_q;
        db_prev_d = db_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Input stage registers, cleared so no stale press survives a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

    // Firing FSM next state; outputs are derived from the next state so their registers match state and ammo.
    always_comb begin
        state_d = state_q;
        ammo_d  = ammo_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                burst_d = '0;
                timer_d = '0;
                if (press[BTN_MODE]) begin
                    mode_d = mode_q + 2'd1;
                end
                if (press[BTN_FIRE] && (mode_q != 2'd3) && (ammo_q != 5'd0)) begin
                    state_d = FIRE;
                    burst_d = (mode_q == 2'd1) ? BURST_LOAD : BURST_ONE;
                end else if (press[BTN_RELOAD] && (ammo_q < AMMO_FULL)) begin
                    state_d = RELOAD;
                end
            end
            FIRE: begin
                if (ammo_q != 5'd0) begin
                    ammo_d = ammo_q - 5'd1;
                end
                if (burst_q != '0) begin
                    burst_d = burst_q - 1'b1;
                end
                timer_d = '0;
                state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (timer_q == CD_LAST) begin
                    timer_d = '0;
                    if ((ammo_q != 5'd0) &&
                        ((burst_q != '0) || ((mode_q == 2'd2) && db_q[BTN_FIRE]))) begin
                        state_d = FIRE;
                    end else begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELOAD: begin
                if (timer_q == RL_LAST) begin
                    timer_d = '0;
                    ammo_d  = AMMO_FULL;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        shot_d   = (state_d == FIRE);
        reload_d = (state_d == RELOAD);
        empty_d  = (ammo_d == 5'd0);
    end

    // FSM and output registers; reset aborts any cooldown or reload in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ammo_q   <= AMMO_FULL;
            mode_q   <= 2'd0;
            burst_q  <= '0;
            timer_q  <= '0;
            shot_q   <= 1'b0;
            reload_q <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ammo_q   <= ammo_d;
            mode_q   <= mode_d;
            burst_q  <= burst_d;
            timer_q  <= timer_d;
            shot_q   <= shot_d;
            reload_q <= reload_d;
            empty_q  <= empty_d;
        end
    end

    assign ammo       = ammo_q;
    assign shoot_mode = {1'b0, mode_q};
    assign shot_pulse = shot_q;
    assign reloading  = reload_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_shot_controller.sv
// Testbench for shot_controller: directed scenarios followed by random
// button actions, each checked against a transaction-level model of
// ammo, fire mode, shot count and reload duration.
module tb_shot_controller;

   localparam int DEB    = 4;
   localparam int COOL   = 8;
   localparam int RELOAD = 20;
   localparam int MAXA   = 31;
   localparam int BURST  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fireBtn = 1'b0;
   logic       modeBtn = 1'b0;
   logic       reloadBtn = 1'b0;
   logic [4:0] ammo;
   logic [2:0] shootMode;
   logic       shotPulse;
   logic       reloading;
   logic       empty;

   int errors = 0;
   int checks = 0;
   int modeM = 0;
   int ammoM = MAXA;

   int cycle = 0;
   int pulseTotal = 0;
   int reloadTotal = 0;
   int lastPulse = -1000;
   int spacingBad = 0;

   shot_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .COOLDOWN_CYCLES(COOL),
      .RELOAD_CYCLES(RELOAD),
      .MAX_AMMO(MAXA),
      .BURST_LEN(BURST)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .fire_btn(fireBtn),
      .mode_btn(modeBtn),
      .reload_btn(reloadBtn),
      .ammo(ammo),
      .shoot_mode(shootMode),
      .shot_pulse(shotPulse),
      .reloading(reloading),
      .empty(empty)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Monitor on the falling edge: tallies shot pulses, reload cycles, and closely spaced pulses that are not one cooldown apart.
   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (shotPulse === 1'b1) begin
         pulseTotal <= pulseTotal + 1;
         lastPulse  <= cycle;
         if ((cycle - lastPulse <= 20) && (cycle - lastPulse != COOL + 1))
            spacingBad <= spacingBad + 1;
      end
      if (reloading === 1'b1)
         reloadTotal <= reloadTotal + 1;
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a falling edge: holds the chosen buttons for 'hold' cycles, then releases them.
   task automatic applyStimulus(input logic f, input logic m, input logic r, input int hold);
      fireBtn   = f;
      modeBtn   = m;
      reloadBtn = r;
      waitCycles(hold);
      fireBtn   = 1'b0;
      modeBtn   = 1'b0;
      reloadBtn = 1'b0;
   endtask

   // Rounds one fire press should produce. Auto-mode holds are always 9k+5 cycles so the release lands mid-cooldown.
   function automatic int expectedShots(input int m, input int a, input int hold);
      int n;
      if (m == 3 || a == 0) return 0;
      if (m == 0) n = 1;
      else if (m == 1) n = BURST;
      else n = 1 + (hold - 1) / (COOL + 1);
      return (n < a) ? n : a;
   endfunction

   task automatic checkState(input string tag);
      checkOutput({tag, "_ammo"}, int'(ammo), ammoM);
      checkOutput({tag, "_empty"}, int'(empty), (ammoM == 0) ? 1 : 0);
      checkOutput({tag, "_mode"}, int'(shootMode), modeM);
      checkOutput({tag, "_reloading"}, int'(reloading), 0);
   endtask

   task automatic fireAction(input int hold, input bit withReload, input string tag);
      int p0, r0, s0, n, expR;
      p0 = pulseTotal;
      r0 = reloadTotal;
      s0 = spacingBad;
      n = expectedShots(modeM, ammoM, hold);
      expR = (withReload && n == 0 && ammoM < MAXA) ? RELOAD : 0;
      applyStimulus(1'b1, 1'b0, withReload, hold);
      waitCycles(2 + DEB + (n + 2) * (COOL + 1) + RELOAD + 10);
      ammoM = ammoM - n;
      if (expR != 0) ammoM = MAXA;
      checkOutput({tag, "_shots"}, pulseTotal - p0, n);
      checkOutput({tag, "_reload_cycles"}, reloadTotal - r0, expR);
      if (n > 1) checkOutput({tag, "_spacing"}, spacingBad - s0, 0);
      checkState(tag);
   endtask

   task automatic modeAction(input string tag);
      applyStimulus(1'b0, 1'b1, 1'b0, 6);
      waitCycles(15);
      modeM = (modeM + 1) % 4;
      checkState(tag);
   endtask

   task automatic reloadAction(input bit fireInside, input bit modeInside, input string tag);
      int p0, r0, expR;
      p0 = pulseTotal;
      r0 = reloadTotal;
      expR = (ammoM < MAXA) ? RELOAD : 0;
      applyStimulus(1'b0, 1'b0, 1'b1, 6);
      waitCycles(4);
      applyStimulus(fireInside, modeInside, 1'b0, 6);
      waitCycles(40);
      if (expR != 0) ammoM = MAXA;
      checkOutput({tag, "_reload_cycles"}, reloadTotal - r0, expR);
      checkOutput({tag, "_shots"}, pulseTotal - p0, 0);
      checkState(tag);
   endtask

   task automatic bounceAction(input string tag);
      int p0;
      p0 = pulseTotal;
      for (int i = 0; i < 15; i++) begin
         fireBtn = (i % 2 == 0);
         waitCycles(2);
      end
      fireBtn = 1'b0;
      waitCycles(20);
      checkOutput({tag, "_shots"}, pulseTotal - p0, 0);
      checkState(tag);
   endtask

   initial begin
      int p0, r0, hold, sel;

      $display("[TB] start");
      waitCycles(3);
      rst_n = 1'b1;
      checkOutput("reset_ammo", int'(ammo), MAXA);
      checkOutput("reset_mode", int'(shootMode), 0);
      checkOutput("reset_shot", int'(shotPulse), 0);
      checkOutput("reset_reloading", int'(reloading), 0);
      checkOutput("reset_empty", int'(empty), 0);

      fireAction(50, 1'b0, "single_50");
      bounceAction("bounce");
      fireAction(14, 1'b0, "single_14");
      modeAction("mode_to_burst");
      for (int i = 0; i < 9; i++) fireAction(5, 1'b0, "burst_drain");
      fireAction(5, 1'b0, "burst_cut_short");
      fireAction(5, 1'b0, "fire_when_empty");
      reloadAction(1'b1, 1'b1, "reload_from_empty");
      reloadAction(1'b0, 1'b0, "reload_when_full");
      modeAction("mode_to_auto");
      fireAction(41, 1'b0, "auto_41");
      fireAction(185, 1'b0, "auto_long");

      applyStimulus(1'b0, 1'b0, 1'b1, 6);
      waitCycles(6);
      checkOutput("mid_reload_reloading", int'(reloading), 1);
      rst_n = 1'b0;
      waitCycles(1);
      rst_n = 1'b1;
      ammoM = MAXA;
      modeM = 0;
      checkOutput("reset_abort_shot", int'(shotPulse), 0);
      checkState("reset_abort");
      p0 = pulseTotal;
      r0 = reloadTotal;
      waitCycles(40);
      checkOutput("reset_abort_shots", pulseTotal - p0, 0);
      checkOutput("reset_abort_reload_cycles", reloadTotal - r0, 0);
      checkState("reset_abort_settled");

      modeAction("mode_to_burst_2");
      modeAction("mode_to_auto_2");
      fireAction(230, 1'b0, "auto_to_five");
      modeAction("mode_to_safe");
      fireAction(5, 1'b0, "fire_in_safe");
      modeAction("mode_wrap");
      reloadAction(1'b1, 1'b1, "reload_at_five");
      fireAction(10, 1'b1, "fire_beats_reload");
      modeAction("mode_b");
      modeAction("mode_c");
      modeAction("mode_safe_2");
      fireAction(5, 1'b1, "reload_beats_safe_fire");
      modeAction("mode_wrap_2");

      for (int it = 0; it < 20; it++) begin
         sel = int'($urandom_range(0, 5));
         hold = 9 * int'($urandom_range(0, 3)) + 5;
         case (sel)
            0: modeAction("rnd_mode");
            1, 2: fireAction(hold, 1'b0, "rnd_fire");
            3: fireAction(hold, 1'b1, "rnd_fire_reload");
            4: reloadAction((ammoM < MAXA) && ($urandom_range(0, 1) == 1),
                            (ammoM < MAXA) && ($urandom_range(0, 1) == 1), "rnd_reload");
            default: bounceAction("rnd_bounce");
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a button level (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter COOLDOWN_CYCLES, default 5000000: minimum gap between shots (100 ms).
REQ-003 The block SHALL have parameter RELOAD_CYCLES, default 50000000: reload duration (1 s).
REQ-004 The block SHALL have parameter MAX_AMMO, default 31: full magazine, maximum 31.
REQ-005 The block SHALL have parameter BURST_LEN, default 3: shots per burst-mode trigger.
REQ-006 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 fire_btn  input  1  raw fire button, active-high, asynchronous to clk.
REQ-009 mode_btn  input  1  raw mode button, active-high, asynchronous.
REQ-010 reload_btn  input  1  raw reload button, active-high, asynchronous.
REQ-011 ammo  output  5  rounds remaining, unsigned 0..MAX_AMMO; drives the display stage number input.
REQ-012 shoot_mode  output  3  fire mode 0..3, bit 2 always 0; drives the display stage mode input.
REQ-013 shot_pulse  output  1  one-cycle high per round fired.
REQ-014 reloading  output  1  high while in state RELOAD.
REQ-015 empty  output  1  high exactly when ammo == 0.

Function
REQ-016 Each button input SHALL pass a two-flop synchronizer, then a debouncer whose accepted level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 A press event SHALL be a one-cycle rising edge of the debounced level; a release produces no event.
REQ-018 Modes SHALL be: 0 single (one shot per press), 1 burst (BURST_LEN shots per press), 2 auto (repeat while held), 3 safe (no firing).
REQ-019 A mode press in IDLE SHALL advance shoot_mode by 1, wrapping 3 -> 0; a mode press in any other state SHALL be discarded.
REQ-020 FSM states SHALL be IDLE, FIRE, COOLDOWN, RELOAD.
REQ-021 IDLE -> FIRE on a fire press when shoot_mode != 3 and ammo > 0; burst counter loads BURST_LEN (mode 1) or 1 (other modes).
REQ-022 A fire press with ammo == 0 or shoot_mode == 3 SHALL be ignored: no shot_pulse, no state change.
REQ-023 FIRE SHALL last exactly one cycle: shot_pulse = 1, ammo decrements by 1, burst counter decrements by 1, next state COOLDOWN.
REQ-024 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, then go to FIRE if burst counter > 0 and ammo > 0, or to FIRE in mode 2 if debounced fire is still high and ammo > 0; otherwise to IDLE.
REQ-025 A burst SHALL stop early when ammo reaches 0; remaining burst count is cleared on return to IDLE.
REQ-026 IDLE -> RELOAD on a reload press when ammo < MAX_AMMO; a reload press with a full magazine, or in any state other than IDLE, SHALL be ignored.
REQ-027 RELOAD SHALL last exactly RELOAD_CYCLES cycles, then set ammo = MAX_AMMO and return to IDLE; fire and mode presses during RELOAD SHALL be discarded.
REQ-028 When fire and reload presses occur in the same IDLE cycle, fire SHALL win if it is valid under REQ-021; otherwise reload is evaluated.
REQ-029 ammo SHALL never wrap below 0 or exceed MAX_AMMO.
REQ-030 All outputs SHALL be registered; empty and reloading SHALL be consistent with ammo and state in the same cycle.

Reset
REQ-031 While rst_n == 0 at a clock edge, the block SHALL force state IDLE, ammo = MAX_AMMO, shoot_mode = 0, shot_pulse = 0, reloading = 0, empty = 0, burst counter 0, all timers 0, and debounced levels 0.
REQ-032 Reset asserted mid-COOLDOWN or mid-RELOAD SHALL abort the operation with no shot_pulse or ammo update.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, RELOAD_CYCLES=20, MAX_AMMO=31, BURST_LEN=3)
REQ-033 Reset, then a single 50-cycle fire press in mode 0 -> exactly one shot_pulse, ammo 31 -> 30, state back to IDLE.
REQ-034 Mode press once, then a fire press with ammo = 2 -> two shot_pulses 9 cycles apart, ammo = 0, empty = 1, burst cut short.
REQ-035 Mode 2, fire held 40 cycles after acceptance -> shot_pulse every 9 cycles while held, none after release plus cooldown.
REQ-036 Fire input toggling every 2 cycles for 30 cycles -> no shot_pulse (debounce rejects bounce).
REQ-037 Reload press at ammo = 5 -> reloading = 1 for 20 cycles, then ammo = 31; a fire press inside that window produces no pulse.
REQ-038 rst_n low for 1 cycle mid-RELOAD at ammo = 5 -> ammo = 31, reloading = 0, shoot_mode = 0 on the next cycle.
